wishbone_decoder: RTL

- Parametrised one-master / NUM_SLAVES-slave Wishbone classic address decoder; replaces per-slave point-to-point master/slave links.
- Sits between a processor bus (instruction or data) and its peripherals: boot ROM, LED/output registers, future RTC and codec ports.
- Registered address decode with slave lock for the whole cycle.
- Generates bus errors for unmapped addresses and for slaves that never respond (watchdog timeout).

---
 rtl/wishbone_decoder_pkg.sv | 44 ++++
 rtl/wishbone_decoder_if.sv | 52 +++++
 rtl/wishbone_decoder_timeout_counter.sv | 34 +++
 rtl/wishbone_decoder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/wishbone_decoder_pkg.sv
// Shared types and helpers for the Wishbone address decoder.
// Holds the FSM state encoding, the decode result struct and the
// slave-lookup function used by the top-level decoder.
package wb_decoder_pkg;

    localparam int MAX_SLAVES      = 16;
    localparam int MAX_ADDR_WIDTH  = 64;
    localparam int FAULT_CNT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        DECERR = 2'd2,
        TOERR  = 2'd3
    } state_t;

    typedef struct packed {
        logic       hit;
        logic [3:0] index;
    } decode_t;

    // Bases and masks arrive zero-extended into fixed 64-bit slots so one
    // function serves every ADDR_WIDTH. Scanning downwards lets the lowest
    // matching index overwrite the result, so it wins on overlap.
    function automatic decode_t decode_slave(
        input logic [MAX_ADDR_WIDTH-1:0]            adr,
        input logic [MAX_SLAVES*MAX_ADDR_WIDTH-1:0] bases,
        input logic [MAX_SLAVES*MAX_ADDR_WIDTH-1:0] masks,
        input int                                   num_slaves
    );
        decode_t result;
        result = '0;
        for (int i = MAX_SLAVES - 1; i >= 0; i--) begin
            if ((i < num_slaves) &&
                ((adr & masks[i*MAX_ADDR_WIDTH +: MAX_ADDR_WIDTH]) ==
                 bases[i*MAX_ADDR_WIDTH +: MAX_ADDR_WIDTH])) begin
                result.hit   = 1'b1;
                result.index = 4'(i);
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/wishbone_decoder_if.sv
// Bus bundle between one Wishbone master, the decoder and its slaves.
// Signal suffixes are from the decoder's point of view.
interface wishbone_decoder_if
    import wb_decoder_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = DATA_WIDTH / 8,
    parameter int TGA_WIDTH  = 2,
    parameter int TGC_WIDTH  = 3
);
    logic                             m_cyc_i, m_stb_i, m_we_i;
    logic [ADDR_WIDTH-1:0]            m_adr_i;
    logic [DATA_WIDTH-1:0]            m_dat_i;
    logic [SEL_WIDTH-1:0]             m_sel_i;
    logic [TGA_WIDTH-1:0]             m_tga_i;
    logic [TGC_WIDTH-1:0]             m_tgc_i;
    logic [DATA_WIDTH-1:0]            m_dat_o;
    logic                             m_ack_o, m_err_o, m_rty_o;

    logic [NUM_SLAVES-1:0]            s_cyc_o, s_stb_o;
    logic                             s_we_o;
    logic [ADDR_WIDTH-1:0]            s_adr_o;
    logic [DATA_WIDTH-1:0]            s_dat_o;
    logic [SEL_WIDTH-1:0]             s_sel_o;
    logic [TGA_WIDTH-1:0]             s_tga_o;
    logic [TGC_WIDTH-1:0]             s_tgc_o;
    logic [NUM_SLAVES*DATA_WIDTH-1:0] s_dat_i;
    logic [NUM_SLAVES-1:0]            s_ack_i, s_err_i, s_rty_i;

    logic                             fault_o;
    logic [ADDR_WIDTH-1:0]            fault_adr_o;
    logic [FAULT_CNT_WIDTH-1:0]       fault_count_o;

    // Processor side.
    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, m_tga_i, m_tgc_i,
        input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
        input  fault_o, fault_adr_o, fault_count_o
    );

    // Decoder side: slave to the processor, fan-out to the peripherals.
    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, m_tga_i, m_tgc_i,
        output m_dat_o, m_ack_o, m_err_o, m_rty_o,
        output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o, s_tga_o, s_tgc_o,
        input  s_dat_i, s_ack_i, s_err_i, s_rty_i,
        output fault_o, fault_adr_o, fault_count_o
    );

endinterface

// File: rtl/wishbone_decoder_timeout_counter.sv
// Watchdog for a locked slave access: counts stalled cycles and flags the
// cycle in which the count would reach TIMEOUT.
module wb_timeout_counter #(
    parameter int TIMEOUT       = 255,
    parameter int TIMEOUT_WIDTH = $clog2(TIMEOUT + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic expired
);
    logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;

    // Fire combinationally so the FSM leaves BUSY on the same edge the
    // count would reach TIMEOUT; clear always dominates.
    always_comb begin
        expired = enable && !clear && (cnt_q == TIMEOUT_WIDTH'(TIMEOUT - 1));
        cnt_d   = cnt_q + TIMEOUT_WIDTH'(1);
        if (clear || !enable || expired) begin
            cnt_d = '0;
        end
    end

    // Count register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wishbone_decoder.sv
// One-master / NUM_SLAVES-slave Wishbone classic address decoder with a
// registered decode, per-cycle slave lock and decoder-generated bus errors
// for unmapped addresses and silent slaves.
// Optional fault logging (address + saturating count): WB_DECODER_FAULT_LOG_EN.
//
// state  | meaning
// IDLE   | waiting for cyc & stb, decoding the address
// BUSY   | locked to sel_q, responses pass through, watchdog running
// DECERR | one-cycle error for an unmapped address
// TOERR  | one-cycle error after the selected slave stalled too long
module wishbone_decoder
    import wb_decoder_pkg::*;
#(
    parameter int                            NUM_SLAVES    = 4,
    parameter int                            ADDR_WIDTH    = 32,
    parameter int                            DATA_WIDTH    = 32,
    parameter int                            SEL_WIDTH     = DATA_WIDTH / 8,
    parameter int                            TGA_WIDTH     = 2,
    parameter int                            TGC_WIDTH     = 3,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE =
        {32'hA000_0000, 32'h9000_0000, 32'h8000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK =
        {32'hF000_0000, 32'hFFFF_0000, 32'hFFFF_FF00, 32'hFFFF_F000},
    parameter int                            TIMEOUT       = 255,
    parameter int                            TIMEOUT_WIDTH = $clog2(TIMEOUT + 1)
) (
    input  logic               clock,
    input  logic               reset,
    wishbone_decoder_if.slave  bus
);
    localparam int SEL_IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    state_t                                state_q, state_d;
    logic [SEL_IDX_W-1:0]                  sel_q, sel_d;
    logic [MAX_SLAVES*MAX_ADDR_WIDTH-1:0]  bases_ext, masks_ext;
    decode_t                               dec;
    logic [DATA_WIDTH-1:0]                 sel_dat;
    logic                                  sel_ack, sel_err, sel_rty, sel_resp;
    logic                                  wd_enable, wd_clear, wd_expired;

    // Broadcast signals follow the master untouched.
    assign bus.s_we_o  = bus.m_we_i;
    assign bus.s_adr_o = ADDR_WIDTH'(bus.m_adr_i);
    assign bus.s_dat_o = DATA_WIDTH'(bus.m_dat_i);
    assign bus.s_sel_o = SEL_WIDTH'(bus.m_sel_i);
    assign bus.s_tga_o = TGA_WIDTH'(bus.m_tga_i);
    assign bus.s_tgc_o = TGC_WIDTH'(bus.m_tgc_i);

    // Widen the decode table into the fixed slot layout the package expects.
    always_comb begin
        bases_ext = '0;
        masks_ext = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            bases_ext[i*MAX_ADDR_WIDTH +: ADDR_WIDTH] = SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH];
            masks_ext[i*MAX_ADDR_WIDTH +: ADDR_WIDTH] = SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
        dec = decode_slave(MAX_ADDR_WIDTH'(bus.m_adr_i), bases_ext, masks_ext, NUM_SLAVES);
    end

    // Response mux from the locked slave.
    always_comb begin
        sel_dat = '0;
        sel_ack = 1'b0;
        sel_err = 1'b0;
        sel_rty = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (SEL_IDX_W'(i) == sel_q) begin
                sel_dat = bus.s_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
                sel_ack = bus.s_ack_i[i];
                sel_err = bus.s_err_i[i];
                sel_rty = bus.s_rty_i[i];
            end
        end
        sel_resp = sel_ack | sel_err | sel_rty;
    end

    assign wd_enable = (state_q == BUSY) && bus.m_stb_i && !sel_resp;
    assign wd_clear  = (state_q != BUSY) || sel_resp;

    wb_timeout_counter #(
        .TIMEOUT       (TIMEOUT),
        .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .enable  (wd_enable),
        .clear   (wd_clear),
        .expired (wd_expired)
    );

    // Next-state and master/slave outputs.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        bus.s_cyc_o = '0;
        bus.s_stb_o = '0;
        bus.m_dat_o = '0;
        bus.m_ack_o = 1'b0;
        bus.m_err_o = 1'b0;
        bus.m_rty_o = 1'b0;
        bus.fault_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.m_cyc_i && bus.m_stb_i) begin
                    if (dec.hit) begin
                        sel_d   = SEL_IDX_W'(dec.index);
                        state_d = BUSY;
                    end else begin
                        state_d = DECERR;
                    end
                end
            end
            BUSY: begin
                for (int i = 0; i < NUM_SLAVES; i++) begin
                    if (SEL_IDX_W'(i) == sel_q) begin
                        bus.s_cyc_o[i] = bus.m_cyc_i;
                        bus.s_stb_o[i] = bus.m_stb_i;
                    end
                end
                bus.m_dat_o = sel_dat;
                bus.m_ack_o = sel_ack;
                bus.m_err_o = sel_err;
                bus.m_rty_o = sel_rty;
                if (!bus.m_cyc_i) begin
                    state_d = IDLE;
                end else if (wd_expired) begin
                    state_d = TOERR;
                end
            end
            DECERR, TOERR: begin
                bus.m_err_o = 1'b1;
                bus.fault_o = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and slave-select registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

`ifdef WB_DECODER_FAULT_LOG_EN
    logic [ADDR_WIDTH-1:0]      adr_q, adr_d, fault_adr_q, fault_adr_d;
    logic [FAULT_CNT_WIDTH-1:0] fault_cnt_q, fault_cnt_d;
    logic                       fault_entry;

    // Track the decode address and log it on entry to either error state.
    always_comb begin
        adr_d = adr_q;
        if (state_q == IDLE && bus.m_cyc_i && bus.m_stb_i) begin
            adr_d = bus.m_adr_i;
        end
        fault_entry = (state_q == IDLE || state_q == BUSY) &&
                      (state_d == DECERR || state_d == TOERR);
        fault_adr_d = fault_entry ? adr_d : fault_adr_q;
        fault_cnt_d = fault_cnt_q;
        if (fault_entry && fault_cnt_q != '1) begin
            fault_cnt_d = fault_cnt_q + FAULT_CNT_WIDTH'(1);
        end
    end

    // Fault log registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            adr_q       <= '0;
            fault_adr_q <= '0;
            fault_cnt_q <= '0;
        end else begin
            adr_q       <= adr_d;
            fault_adr_q <= fault_adr_d;
            fault_cnt_q <= fault_cnt_d;
        end
    end

    assign bus.fault_adr_o   = fault_adr_q;
    assign bus.fault_count_o = fault_cnt_q;
`else
    assign bus.fault_adr_o   = '0;
    assign bus.fault_count_o = '0;
`endif

endmodule
